// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
package dpram_arb_pkg;

    localparam int unsigned NREQ_MAX   = 8;
    localparam int unsigned IDX_W      = 3;
    // Command fields are sized for the widest supported RAM; the top uses the low bits.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 64;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
        logic is_read;
    } rsp_t;

    function automatic idx_t wrap_inc(input idx_t i, input int unsigned n);
        return (32'(i) + 32'd1 >= n) ? '0 : idx_t'(i + 1'b1);
    endfunction

endpackage

// File: rtl/dual_port_ram_arbiter_rr_pick.sv
// Combinational rotating-priority search: first set bit of mask & ~excl from start, mod N.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] mask,
    input  idx_t         start,
    input  logic [N-1:0] excl,
    output logic         found,
    output idx_t         idx
);

    logic [N-1:0] cand;
    int unsigned  c;

    assign cand = mask & ~excl;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(start) + k) % N;
            if (!found && |(cand & (N'(1) << c))) begin
                found = 1'b1;
                idx   = idx_t'(c);
            end
        end
    end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin scheduler granting up to two requesters per cycle onto a dual-port synchronous RAM.
module dual_port_ram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [NREQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0]      ram_addr1,
    inout  logic [DATA_WIDTH-1:0]      ram_data1,
    output logic                       ram_cs1,
    output logic                       ram_we1,
    output logic                       ram_oe1,
    output logic [ADDR_WIDTH-1:0]      ram_addr2,
    inout  logic [DATA_WIDTH-1:0]      ram_data2,
    output logic                       ram_cs2,
    output logic                       ram_we2,
    output logic                       ram_oe2
);

    logic [ADDR_WIDTH-1:0] addr_of  [NREQ];
    logic [DATA_WIDTH-1:0] wdata_of [NREQ];
    logic [DATA_WIDTH-1:0] rdata_q  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign addr_of[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_of[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q[g];
    end

    idx_t                  ptr;
    idx_t                  idx1, idx2, start2;
    logic                  found1, found2, grant1, grant2;
    logic [NREQ-1:0]       excl2;
    logic                  sel1_we, sel2_we;
    logic [ADDR_WIDTH-1:0] sel1_addr, sel2_addr;
    logic [DATA_WIDTH-1:0] sel1_wdata, sel2_wdata;

    cmd_t            cmd1_q, cmd2_q;
    logic            act1_q, act2_q;
    rsp_t            rsp1_q, rsp2_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            unused_cmd_bits;

    assign start2 = wrap_inc(idx1, NREQ);

    rr_pick #(.N(NREQ)) u_pick1 (
        .mask  (req_valid),
        .start (ptr),
        .excl  ('0),
        .found (found1),
        .idx   (idx1)
    );

    rr_pick #(.N(NREQ)) u_pick2 (
        .mask  (req_valid),
        .start (start2),
        .excl  (excl2),
        .found (found2),
        .idx   (idx2)
    );

    assign grant1 = found1 && !rst;
    assign grant2 = found2 && !rst;

    // Port-2 candidates exclude the port-1 winner and any same-address hazard involving a write.
    always_comb begin
        sel1_we    = 1'b0;
        sel1_addr  = '0;
        sel1_wdata = '0;
        excl2      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (idx1 == idx_t'(i)) begin
                sel1_we    = req_we[i];
                sel1_addr  = addr_of[i];
                sel1_wdata = wdata_of[i];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            excl2[i] = (idx1 == idx_t'(i)) ||
                       ((addr_of[i] == sel1_addr) && (req_we[i] || sel1_we));
        end
    end

    always_comb begin
        sel2_we    = 1'b0;
        sel2_addr  = '0;
        sel2_wdata = '0;
        req_ready  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (idx2 == idx_t'(i)) begin
                sel2_we    = req_we[i];
                sel2_addr  = addr_of[i];
                sel2_wdata = wdata_of[i];
            end
            req_ready[i] = (grant1 && idx1 == idx_t'(i)) || (grant2 && idx2 == idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            act1_q      <= 1'b0;
            act2_q      <= 1'b0;
            cmd1_q      <= '0;
            cmd2_q      <= '0;
            rsp1_q      <= '0;
            rsp2_q      <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '{default: '0};
        end else begin
            if (grant2) begin
                ptr <= wrap_inc(idx2, NREQ);
            end else if (grant1) begin
                ptr <= wrap_inc(idx1, NREQ);
            end

            act1_q <= grant1;
            act2_q <= grant2;
            if (grant1) begin
                cmd1_q <= '{we: sel1_we, addr: CMD_ADDR_W'(sel1_addr), wdata: CMD_DATA_W'(sel1_wdata)};
            end
            if (grant2) begin
                cmd2_q <= '{we: sel2_we, addr: CMD_ADDR_W'(sel2_addr), wdata: CMD_DATA_W'(sel2_wdata)};
            end
            rsp1_q <= '{valid: grant1, idx: idx1, is_read: !sel1_we};
            rsp2_q <= '{valid: grant2, idx: idx2, is_read: !sel2_we};

            // The RAM drives read data in the second half of the command cycle; capture it here.
            for (int unsigned i = 0; i < NREQ; i++) begin
                rsp_valid_q[i] <= (rsp1_q.valid && rsp1_q.idx == idx_t'(i)) ||
                                  (rsp2_q.valid && rsp2_q.idx == idx_t'(i));
                if (rsp1_q.valid && rsp1_q.is_read && rsp1_q.idx == idx_t'(i)) begin
                    rdata_q[i] <= ram_data1;
                end else if (rsp2_q.valid && rsp2_q.is_read && rsp2_q.idx == idx_t'(i)) begin
                    rdata_q[i] <= ram_data2;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;

    assign ram_cs1   = act1_q;
    assign ram_we1   = act1_q && cmd1_q.we;
    assign ram_oe1   = act1_q && !cmd1_q.we;
    assign ram_addr1 = cmd1_q.addr[ADDR_WIDTH-1:0];
    assign ram_data1 = (ram_cs1 && ram_we1) ? cmd1_q.wdata[DATA_WIDTH-1:0] : 'z;

    assign ram_cs2   = act2_q;
    assign ram_we2   = act2_q && cmd2_q.we;
    assign ram_oe2   = act2_q && !cmd2_q.we;
    assign ram_addr2 = cmd2_q.addr[ADDR_WIDTH-1:0];
    assign ram_data2 = (ram_cs2 && ram_we2) ? cmd2_q.wdata[DATA_WIDTH-1:0] : 'z;

    assign unused_cmd_bits = ^{cmd1_q, cmd2_q};

endmodule
